// File: rtl/arbitrated_memory_interface_pkg.sv
// Shared constants and helpers for the arbitrated memory interface.
package arbitrated_memory_interface_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Width of a port identifier; never narrower than one bit.
  function automatic int unsigned port_id_bits(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/arbitrated_memory_interface_id_fifo.sv
// In-order FIFO of port IDs for reads that are in flight downstream.
module arbiter_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while empty so no reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/arbitrated_memory_interface.sv
// Arbitrates NUM_PORTS request channels onto one downstream port and routes
// read responses back to the issuing port in order.
module arbitrated_memory_interface
  import arbitrated_memory_interface_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDRESS_BITS    = 32,
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ARB_MODE        = ARB_FIXED
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             port_read,
  input  logic [NUM_PORTS-1:0]             port_write,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_byte_en,
  input  logic [NUM_PORTS*ADDRESS_BITS-1:0] port_address_out,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   port_data_out,
  output logic [NUM_PORTS-1:0]             port_ready,
  output logic [NUM_PORTS-1:0]             port_valid,
  output logic [DATA_WIDTH-1:0]            port_data_in,
  output logic [ADDRESS_BITS-1:0]          port_address_in,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [DATA_WIDTH/8-1:0]          mem_byte_en,
  output logic [ADDRESS_BITS-1:0]          mem_address_in,
  output logic [DATA_WIDTH-1:0]            mem_data_in,
  input  logic                             mem_ready,
  input  logic                             mem_valid,
  input  logic [DATA_WIDTH-1:0]            mem_data_out,
  input  logic [ADDRESS_BITS-1:0]          mem_address_out,
  output logic                             resp_error
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned ID_W  = port_id_bits(NUM_PORTS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned OUT_W = CNT_W + 1;

  // Pending slot (doubles as the registered downstream request).
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [BE_W-1:0]         mem_be_q, mem_be_d;
  logic [ADDRESS_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic [ID_W-1:0]         pend_id_q, pend_id_d;
  logic [ID_W-1:0]         last_q, last_d;
  // Response path.
  logic [NUM_PORTS-1:0]    port_valid_q, port_valid_d;
  logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic [ADDRESS_BITS-1:0] resp_addr_q, resp_addr_d;
  logic                    resp_error_q, resp_error_d;

  logic [NUM_PORTS-1:0]    eligible;
  logic [NUM_PORTS-1:0]    grant_c;
  logic                    grant_any;
  logic [ID_W-1:0]         grant_id;
  int unsigned             arb_idx;
  logic                    slot_free, read_ok;
  logic [OUT_W-1:0]        outstanding;
  logic                    sel_write;
  logic [BE_W-1:0]         sel_be;
  logic [ADDRESS_BITS-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ID_W-1:0]         fifo_head;
  logic [CNT_W-1:0]        fifo_count;

  assign fifo_push = mem_read_q & mem_ready;
  assign fifo_pop  = mem_valid;

  arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (pend_id_q),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Eligibility and arbitration; no grants are issued while in reset.
  always_comb begin
    slot_free   = ~(mem_read_q | mem_write_q) | mem_ready;
    outstanding = OUT_W'(fifo_count) + OUT_W'(mem_read_q);
    read_ok     = ~fifo_full & (outstanding < OUT_W'(MAX_OUTSTANDING));
    eligible    = '0;
    grant_any   = 1'b0;
    grant_id    = '0;
    arb_idx     = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = reset & slot_free & (port_write[i] | (port_read[i] & read_ok));
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (ARB_MODE == ARB_RR) begin
        arb_idx = 32'(last_q) + 32'(k) + 32'd1;
        if (arb_idx >= NUM_PORTS) arb_idx = arb_idx - NUM_PORTS;
      end else begin
        arb_idx = 32'(k);
      end
      if (!grant_any && eligible[ID_W'(arb_idx)]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(arb_idx);
      end
    end
    grant_c = grant_any ? (NUM_PORTS'(1) << grant_id) : '0;
  end

  // Payload mux for the winning port; read+write counts as a write.
  always_comb begin
    sel_write = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_c[i]) begin
        sel_write = port_write[i];
        sel_be    = port_byte_en[i*BE_W +: BE_W];
        sel_addr  = port_address_out[i*ADDRESS_BITS +: ADDRESS_BITS];
        sel_data  = port_data_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state for the pending slot, round-robin pointer and response path.
  always_comb begin
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    pend_id_d    = pend_id_q;
    last_d       = last_q;
    port_valid_d = '0;
    resp_data_d  = resp_data_q;
    resp_addr_d  = resp_addr_q;
    resp_error_d = resp_error_q;

    if (grant_any) begin
      mem_read_d  = ~sel_write;
      mem_write_d = sel_write;
      mem_be_d    = sel_be;
      mem_addr_d  = sel_addr;
      mem_data_d  = sel_data;
      pend_id_d   = grant_id;
      last_d      = grant_id;
    end else if (mem_ready) begin
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end

    if (mem_valid) begin
      if (!fifo_empty) begin
        port_valid_d = NUM_PORTS'(1) << fifo_head;
        resp_data_d  = mem_data_out;
        resp_addr_d  = mem_address_out;
      end else begin
        resp_error_d = 1'b1;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      pend_id_q    <= '0;
      last_q       <= ID_W'(NUM_PORTS - 1);
      port_valid_q <= '0;
      resp_data_q  <= '0;
      resp_addr_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      pend_id_q    <= pend_id_d;
      last_q       <= last_d;
      port_valid_q <= port_valid_d;
      resp_data_q  <= resp_data_d;
      resp_addr_q  <= resp_addr_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign port_ready      = grant_c;
  assign port_valid      = port_valid_q;
  assign port_data_in    = resp_data_q;
  assign port_address_in = resp_addr_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_en     = mem_be_q;
  assign mem_address_in  = mem_addr_q;
  assign mem_data_in     = mem_data_q;
  assign resp_error      = resp_error_q;

endmodule

// File: tb/tb_arbitrated_memory_interface.sv
// Bench: directed scenarios plus randomized traffic against a queue-based model.
// Instance 0 uses fixed priority, instance 1 round-robin.
module tb_arbitrated_memory_interface;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  rd [2], wr [2], rdy [2], pval [2];
  logic [7:0]  be [2];
  logic [63:0] addr [2], wdata [2];
  logic        mrdy [2], mval [2], mrd [2], mwr [2], rerr [2];
  logic [31:0] mdat [2], madr [2], pdata [2], paddr [2], maddr [2], mdin [2];
  logic [3:0]  mbe [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  arbitrated_memory_interface #(
    .DATA_WIDTH(32), .ADDRESS_BITS(32), .NUM_PORTS(2), .MAX_OUTSTANDING(4), .ARB_MODE(0)
  ) u_fix (
    .clock(clock), .reset(reset), .port_read(rd[0]), .port_write(wr[0]),
    .port_byte_en(be[0]), .port_address_out(addr[0]), .port_data_out(wdata[0]),
    .port_ready(rdy[0]), .port_valid(pval[0]), .port_data_in(pdata[0]),
    .port_address_in(paddr[0]), .mem_read(mrd[0]), .mem_write(mwr[0]),
    .mem_byte_en(mbe[0]), .mem_address_in(maddr[0]), .mem_data_in(mdin[0]),
    .mem_ready(mrdy[0]), .mem_valid(mval[0]), .mem_data_out(mdat[0]),
    .mem_address_out(madr[0]), .resp_error(rerr[0])
  );

  arbitrated_memory_interface #(
    .DATA_WIDTH(32), .ADDRESS_BITS(32), .NUM_PORTS(2), .MAX_OUTSTANDING(4), .ARB_MODE(1)
  ) u_rr (
    .clock(clock), .reset(reset), .port_read(rd[1]), .port_write(wr[1]),
    .port_byte_en(be[1]), .port_address_out(addr[1]), .port_data_out(wdata[1]),
    .port_ready(rdy[1]), .port_valid(pval[1]), .port_data_in(pdata[1]),
    .port_address_in(paddr[1]), .mem_read(mrd[1]), .mem_write(mwr[1]),
    .mem_byte_en(mbe[1]), .mem_address_in(maddr[1]), .mem_data_in(mdin[1]),
    .mem_ready(mrdy[1]), .mem_valid(mval[1]), .mem_data_out(mdat[1]),
    .mem_address_out(madr[1]), .resp_error(rerr[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    for (int u = 0; u < 2; u++) begin
      rd[u] = '0; wr[u] = '0; be[u] = '0; addr[u] = '0; wdata[u] = '0;
      mrdy[u] = 1'b1; mval[u] = 1'b0; mdat[u] = '0; madr[u] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check_all_zero(input int u, input string tag);
    check_eq({tag, "_mem_read"}, mrd[u], 0);
    check_eq({tag, "_mem_write"}, mwr[u], 0);
    check_eq({tag, "_port_valid"}, pval[u], 0);
    check_eq({tag, "_resp_error"}, rerr[u], 0);
    check_eq({tag, "_mem_addr"}, maddr[u], 0);
    check_eq({tag, "_mem_data"}, mdin[u], 0);
    check_eq({tag, "_mem_be"}, mbe[u], 0);
    check_eq({tag, "_port_data"}, pdata[u], 0);
    check_eq({tag, "_port_addr"}, paddr[u], 0);
  endtask

  // Reference model state (transaction level)
  logic        m_pv, m_pw;
  int          m_id, m_last;
  logic [31:0] m_addr, m_data, m_pdata, m_paddr;
  logic [3:0]  m_be;
  logic [1:0]  m_pval;
  int          m_q[$];
  logic        r_act [2], r_rd [2], r_wr [2];
  logic [31:0] r_addr [2], r_data [2];
  logic [3:0]  r_be [2];

  task automatic run_random(input int u, input int n);
    int g, p, outst, kind, id;
    logic free, mv;
    do_reset();
    m_pv = 0; m_pw = 0; m_id = 0; m_last = 1; m_addr = 0; m_data = 0; m_be = 0;
    m_pval = 0; m_pdata = 0; m_paddr = 0; m_q.delete();
    for (int i = 0; i < 2; i++) r_act[i] = 0;
    for (int c = 0; c < n; c++) begin
      check_eq("rnd_mem_read", mrd[u], m_pv && !m_pw);
      check_eq("rnd_mem_write", mwr[u], m_pv && m_pw);
      check_eq("rnd_mem_addr", maddr[u], m_addr);
      check_eq("rnd_mem_data", mdin[u], m_data);
      check_eq("rnd_mem_be", mbe[u], m_be);
      check_eq("rnd_port_valid", pval[u], m_pval);
      check_eq("rnd_port_data", pdata[u], m_pdata);
      check_eq("rnd_port_addr", paddr[u], m_paddr);
      check_eq("rnd_resp_error", rerr[u], 0);
      for (int i = 0; i < 2; i++) begin
        if (!r_act[i] && $urandom_range(0, 99) < 60) begin
          kind = $urandom_range(0, 3);
          r_act[i] = 1; r_rd[i] = (kind != 2); r_wr[i] = (kind >= 2);
          r_addr[i] = $urandom; r_data[i] = $urandom; r_be[i] = 4'($urandom);
        end
        rd[u][i] = r_act[i] & r_rd[i];
        wr[u][i] = r_act[i] & r_wr[i];
        addr[u][i*32 +: 32] = r_addr[i];
        wdata[u][i*32 +: 32] = r_data[i];
        be[u][i*4 +: 4] = r_be[i];
      end
      mrdy[u] = ($urandom_range(0, 3) != 0);
      mv = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      mval[u] = mv;
      mdat[u] = $urandom;
      madr[u] = $urandom;
      #1;
      free = !m_pv || mrdy[u];
      outst = m_q.size() + ((m_pv && !m_pw) ? 1 : 0);
      g = -1;
      for (int k = 0; k < 2; k++) begin
        p = (u == 1) ? (m_last + 1 + k) % 2 : k;
        if (g < 0 && r_act[p] && free && (r_wr[p] || outst < 4)) g = p;
      end
      check_eq("rnd_port_ready", rdy[u], (g < 0) ? 0 : (1 << g));
      if (mv) begin
        id = m_q.pop_front();
        m_pval = 2'(1 << id); m_pdata = mdat[u]; m_paddr = madr[u];
      end else begin
        m_pval = 0;
      end
      if (m_pv && !m_pw && mrdy[u]) m_q.push_back(m_id);
      if (g >= 0) begin
        m_pv = 1; m_pw = r_wr[g]; m_id = g; m_last = g;
        m_addr = r_addr[g]; m_data = r_data[g]; m_be = r_be[g];
        r_act[g] = 0;
      end else if (mrdy[u]) begin
        m_pv = 0;
      end
      tick();
    end
    idle_inputs();
  endtask

  logic [1:0]  exp_g [3];
  logic [31:0] exp_d [3];

  initial begin
    idle_inputs();
    do_reset();
    check_all_zero(0, "reset_fix");
    check_all_zero(1, "reset_rr");

    // Single read on port 0
    rd[1] = 2'b01; addr[1] = {32'h0, 32'h11111111};
    #1 check_eq("t1_ready", rdy[1], 2'b01);
    tick();
    rd[1] = 2'b00;
    check_eq("t1_mem_read", mrd[1], 1);
    check_eq("t1_mem_addr", maddr[1], 32'h11111111);
    tick();
    check_eq("t1_mem_read_drop", mrd[1], 0);
    mval[1] = 1; mdat[1] = 32'h22222222; madr[1] = 32'h11111111;
    tick();
    mval[1] = 0;
    check_eq("t1_port_valid", pval[1], 2'b01);
    check_eq("t1_port_data", pdata[1], 32'h22222222);
    check_eq("t1_port_addr", paddr[1], 32'h11111111);
    tick();
    check_eq("t1_port_valid_once", pval[1], 2'b00);

    // Fixed priority starvation then in-order responses
    do_reset();
    rd[0] = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1 check_eq("t2_fixed_grant", rdy[0], 2'b01);
      tick();
    end
    rd[0] = 2'b00;
    tick();
    for (int c = 0; c < 3; c++) begin
      mval[0] = 1; mdat[0] = 32'h30 + 32'(c);
      tick();
      check_eq("t2_resp_port", pval[0], 2'b01);
      check_eq("t2_resp_data", pdata[0], 32'h30 + 32'(c));
    end
    mval[0] = 0;

    // Round-robin alternation and response routing
    do_reset();
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC;
    rd[1] = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1 check_eq("t3_rr_grant", rdy[1], exp_g[c]);
      tick();
    end
    rd[1] = 2'b00;
    tick();
    for (int c = 0; c < 3; c++) begin
      mval[1] = 1; mdat[1] = exp_d[c];
      tick();
      check_eq("t3_rr_resp_port", pval[1], exp_g[c]);
      check_eq("t3_rr_resp_data", pdata[1], exp_d[c]);
    end
    mval[1] = 0;

    // Write held while downstream stalls
    do_reset();
    wr[0] = 2'b10; addr[0] = {32'h12341234, 32'h0}; wdata[0] = {32'h99999999, 32'h0};
    be[0] = 8'b0011_0000; mrdy[0] = 0;
    #1 check_eq("t4_ready", rdy[0], 2'b10);
    tick();
    wr[0] = 2'b00;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mrdy[0] = 1;
      check_eq("t4_mem_write", mwr[0], 1);
      check_eq("t4_mem_read", mrd[0], 0);
      check_eq("t4_mem_addr", maddr[0], 32'h12341234);
      check_eq("t4_mem_data", mdin[0], 32'h99999999);
      check_eq("t4_mem_be", mbe[0], 4'b0011);
      check_eq("t4_port_valid", pval[0], 0);
      tick();
    end
    check_eq("t4_write_done", mwr[0], 0);
    mval[0] = 1;
    tick();
    mval[0] = 0;
    check_eq("t4_no_push_error", rerr[0], 1);
    check_eq("t4_no_push_valid", pval[0], 0);

    // Outstanding limit: blocked read, write passes, response frees a slot
    do_reset();
    rd[0] = 2'b01;
    for (int c = 0; c < 4; c++) begin
      #1 check_eq("t5_read_grant", rdy[0], 2'b01);
      tick();
    end
    wr[0] = 2'b10;
    #1 check_eq("t5_write_bypass", rdy[0], 2'b10);
    tick();
    wr[0] = 2'b00;
    #1 check_eq("t5_read_blocked", rdy[0], 2'b00);
    mval[0] = 1; mdat[0] = 32'h55;
    tick();
    mval[0] = 0;
    #1 check_eq("t5_read_regrant", rdy[0], 2'b01);
    check_eq("t5_resp_port", pval[0], 2'b01);
    tick();

    // Stray response, then reset mid-burst
    do_reset();
    rd[0] = 2'b01;
    tick();
    rd[0] = 2'b00;
    tick();
    mval[0] = 1; mdat[0] = 32'hCAFE;
    tick();
    check_eq("t6_good_resp", pval[0], 2'b01);
    tick();
    mval[0] = 0;
    check_eq("t6_stray_error", rerr[0], 1);
    check_eq("t6_stray_no_valid", pval[0], 0);
    rd[0] = 2'b01;
    tick();
    tick();
    reset = 1'b0;
    #1 check_eq("t6_no_grant_in_reset", rdy[0], 2'b00);
    tick();
    check_all_zero(0, "t6_midreset");
    rd[0] = 2'b11; rd[1] = 2'b11;
    reset = 1'b1;
    #1 check_eq("t6_fix_first", rdy[0], 2'b01);
    check_eq("t6_rr_first", rdy[1], 2'b01);
    idle_inputs();

    run_random(0, 400);
    run_random(1, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitrated_memory_interface.md
Name: arbitrated_memory_interface

Overview:
- Parametrised successor to the combinational fetch/memory pass-through interface.
- Multiplexes NUM_PORTS pipeline-side request channels (port 0 is normally fetch, port 1 the memory stage) onto one shared downstream memory/cache port.
- Registered issue stage, selectable fixed-priority or round-robin arbitration.
- In-order tracking of up to MAX_OUTSTANDING reads, so each read response is routed back to the port that issued it.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (multiple of 8)
- ADDRESS_BITS, 32, address width
- NUM_PORTS, 2, number of request channels (2..8)
- MAX_OUTSTANDING, 4, read responses in flight (power of 2, >=2)
- ARB_MODE, 0, 0 = fixed priority (port 0 highest), 1 = round-robin

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- port_read  in  NUM_PORTS  per-port read request
- port_write  in  NUM_PORTS  per-port write request
- port_byte_en  in  NUM_PORTS*DATA_WIDTH/8  flattened byte enables, port i at slice i
- port_address_out  in  NUM_PORTS*ADDRESS_BITS  flattened request addresses
- port_data_out  in  NUM_PORTS*DATA_WIDTH  flattened write data
- port_ready  out  NUM_PORTS  one-hot grant; request accepted in this cycle
- port_valid  out  NUM_PORTS  one-hot read-response strobe
- port_data_in  out  DATA_WIDTH  response data, shared by all ports, qualified by port_valid
- port_address_in  out  ADDRESS_BITS  response address, shared by all ports
- mem_read  out  1  downstream read
- mem_write  out  1  downstream write
- mem_byte_en  out  DATA_WIDTH/8  downstream byte enables
- mem_address_in  out  ADDRESS_BITS  downstream address
- mem_data_in  out  DATA_WIDTH  downstream write data
- mem_ready  in  1  downstream accepts the presented request this cycle
- mem_valid  in  1  downstream read response valid
- mem_data_out  in  DATA_WIDTH  downstream response data
- mem_address_out  in  ADDRESS_BITS  downstream response address
- resp_error  out  1  sticky: mem_valid arrived with no read outstanding

Behaviour:
- Reset (reset==0 at an edge):
  - pending slot empty; ID FIFO empty; round-robin pointer selects port 0.
  - resp_error, mem_read, mem_write, port_valid all 0.
  - mem_byte_en, mem_address_in, mem_data_in, port_data_in, port_address_in all 0.
  - Reset mid-operation discards all in-flight state.
- Requests:
  - A port requests when read|write is high.
  - read&write together on one port is treated as a write.
  - The port holds its request and payload until it sees port_ready[i].
- Grant condition: (pending empty OR (pending valid AND mem_ready)). Reads additionally require outstanding < MAX_OUTSTANDING, where outstanding = FIFO count + (pending holds a read). No pop-same-cycle bypass.
- Arbitration, among eligible requesters:
  - ARB_MODE 0: lowest index wins.
  - ARB_MODE 1: search starts at last_granted+1, wrapping modulo NUM_PORTS; pointer updates only on a grant.
  - A blocked read does not block an eligible write on another port.
- Issue:
  - Granted payload and port ID are loaded into the pending slot at the edge after the grant.
  - mem_read/mem_write appear 1 cycle after port_ready and are held stable until mem_ready==1.
  - Throughput is 1 request/cycle while mem_ready stays high.
- Tracking:
  - When a pending read is accepted (mem_ready==1), its port ID is pushed into the ID FIFO.
  - Writes produce no response and are not tracked.
- Response:
  - mem_valid==1 pops the FIFO head.
  - Next cycle: port_valid[head]=1 for exactly 1 cycle; port_data_in/port_address_in are registered copies of mem_data_out/mem_address_out.
  - Response latency is 1 cycle; back-to-back mem_valid gives back-to-back port_valid.
  - A simultaneous push and pop is legal and leaves count unchanged.
- Boundaries:
  - mem_valid with an empty FIFO: response dropped, no port_valid, resp_error set to 1 until reset.
  - FIFO pointers wrap modulo MAX_OUTSTANDING; count saturates at MAX_OUTSTANDING only via the grant rule.

Decomposition:
- Shared package holds the constants: PORT_ID_BITS = clog2(NUM_PORTS), ARB_FIXED = 0, ARB_RR = 1.
- One sub-module: arbiter_id_fifo (depth MAX_OUTSTANDING, width PORT_ID_BITS; push/pop/full/empty/count).
- The arbiter is an internal always block, not a separate module.

Test Plan:
- Single port 0 read, addr 32'h11111111:
  - port_ready[0] in cycle t; mem_read=1, mem_address_in=32'h11111111 in t+1.
  - mem_valid with data 32'h22222222 -> port_valid=2'b01, port_data_in=32'h22222222 one cycle later.
- ARB_MODE 0, ports 0 and 1 reading simultaneously for 3 cycles, mem_ready=1 -> grants 0,0,0; port 1 starves.
- ARB_MODE 1, same stimulus -> grants 0,1,0; responses (data 32'hA, 32'hB, 32'hC) route to ports 0,1,0 in order.
- Write port 1, addr 32'h12341234, data 32'h99999999, byte_en 4'b0011, mem_ready low for 3 cycles:
  - mem_write and payload held stable for 4 cycles.
  - No FIFO push; no port_valid.
- MAX_OUTSTANDING=4, 4 reads accepted with no responses -> fifth read not granted (port_ready=0) while a write on the other port is granted.
  - One mem_valid -> read granted next cycle.
- mem_valid with FIFO empty -> resp_error=1 and no port_valid.
  - Reset asserted mid-burst with 2 reads outstanding -> all outputs 0, resp_error cleared, port 0 granted first after release.
